// File: rtl/trap_ctrl.sv
// Trap/return sequencer: drains mul/div, flushes the pipeline, redirects NPC and commits to CP0 once per trap.
// Optional TRAP_IRQ_SYNC_EN adds a two-flop synchroniser on every irq line.
module trap_ctrl #(
    parameter int NSTAGES   = 5,
    parameter int NIRQ      = 6,
    parameter int EXC_W     = 5,
    parameter int DRAIN_MAX = 40
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NIRQ-1:0]    irq,
    input  logic [NIRQ-1:0]    im,
    input  logic               ie,
    input  logic               exl,
    input  logic               m_valid,
    input  logic [EXC_W-1:0]   m_exc,
    input  logic               m_is_eret,
    input  logic [31:0]        m_pc,
    input  logic               md_busy,
    output logic [NSTAGES-1:0] flush,
    output logic [1:0]         npc_mode,
    output logic               pc_force_en,
    output logic               dm_stop,
    output logic               cp0_we_block,
    output logic               exc_commit,
    output logic               eret_commit,
    output logic [EXC_W-1:0]   exc_code_out,
    output logic               is_int,
    output logic [31:0]        epc_out,
    output logic               busy,
    output logic               drain_timeout
);
    localparam int CNT_W = $clog2(DRAIN_MAX + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DRAIN_MAX - 1);
    localparam logic [NSTAGES-1:0] FLUSH_ALL  = {NSTAGES{1'b1}};
    // eret keeps M and W: only stages younger than M are squashed
    localparam logic [NSTAGES-1:0] FLUSH_ERET = {NSTAGES{1'b1}} >> 2;

    typedef enum logic [1:0] {IDLE, DRAIN, REDIRECT, ERET} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             to_set;
    logic [NIRQ-1:0]  irq_q;
    logic             int_req, is_exc, trap, ret;

`ifdef TRAP_IRQ_SYNC_EN
    logic [NIRQ-1:0] irq_s1, irq_s2;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_s1 <= '0;
            irq_s2 <= '0;
        end else begin
            irq_s1 <= irq;
            irq_s2 <= irq_s1;
        end
    end
    assign irq_q = irq_s2;
`else
    assign irq_q = irq;
`endif

    assign int_req = ie & ~exl & (|(irq_q & im));
    assign is_exc  = (m_exc != '0);
    assign trap    = m_valid & (is_exc | int_req);
    assign ret     = m_valid & m_is_eret & ~trap;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            drain_timeout <= 1'b0;
            exc_code_out  <= '0;
            is_int        <= 1'b0;
            epc_out       <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (to_set)
                drain_timeout <= 1'b1;
            if (state == IDLE && trap) begin
                exc_code_out <= is_exc ? m_exc : '0;
                is_int       <= ~is_exc;
                epc_out      <= m_pc;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        to_set       = 1'b0;
        flush        = '0;
        npc_mode     = 2'b00;
        pc_force_en  = 1'b0;
        dm_stop      = 1'b0;
        cp0_we_block = 1'b0;
        exc_commit   = 1'b0;
        eret_commit  = 1'b0;
        case (state)
            IDLE: begin
                if (trap) begin
                    dm_stop      = 1'b1;
                    cp0_we_block = 1'b1;
                    state_nxt    = md_busy ? DRAIN : REDIRECT;
                end else if (ret) begin
                    state_nxt = ERET;
                end
            end
            DRAIN: begin
                flush        = FLUSH_ALL;
                dm_stop      = 1'b1;
                cp0_we_block = 1'b1;
                if (!md_busy) begin
                    state_nxt = REDIRECT;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = REDIRECT;
                    cnt_nxt   = '0;
                    to_set    = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            REDIRECT: begin
                flush        = FLUSH_ALL;
                npc_mode     = 2'b01;
                pc_force_en  = 1'b1;
                exc_commit   = 1'b1;
                dm_stop      = 1'b1;
                cp0_we_block = 1'b1;
                state_nxt    = IDLE;
            end
            ERET: begin
                flush       = FLUSH_ERET;
                npc_mode    = 2'b10;
                pc_force_en = 1'b1;
                eret_commit = 1'b1;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule
